// File: rtl/sign_magnitude_decoder_pkg.sv
// Shared types and sizing helpers for the sign/magnitude decoder and its serial cells.
// State encoding is fixed so the debug port reads the same across builds.
package sign_magnitude_decoder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sign_magnitude_decoder_serial_negate_cell.sv
// One bit-slice of LSB-first two's-complement negation: pass bits through up to and
// including the first 1, invert every bit after it.
module serial_negate_cell (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_b,
    input  logic i_neg,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit
);

    logic r_seen_one;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_seen_one <= 1'b0;
        end else if (i_enable) begin
            r_seen_one <= r_seen_one | i_b;
        end
    end

    assign o_bit = (i_neg && r_seen_one) ? ~i_b : i_b;

endmodule

// File: rtl/sign_magnitude_decoder.sv
// Two's-complement to sign+magnitude converter, one word in flight, WIDTH serial cycles.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module sign_magnitude_decoder
    import sign_magnitude_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_minneg,
    output state_t           dbg_state
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] r_res;
    logic             r_sign;
    logic             r_minneg_pend;
    logic             r_out_valid;
    logic             r_out_sign;
    logic [WIDTH-1:0] r_out_mag;
    logic             r_out_minneg;

    logic w_accept;
    logic w_shift;
    logic w_last;
    logic w_load;
    logic w_release;
    logic w_bit;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_shift   = (r_state == ST_SHIFT);
    assign w_last    = w_shift && (r_cnt == CNT_W'(WIDTH - 1));
    // DONE spends its first cycle publishing the result, then waits for the consumer.
    assign w_load    = (r_state == ST_DONE) && !r_out_valid;
    assign w_release = (r_state == ST_DONE) && r_out_valid && out_ready;

    serial_negate_cell u_cell (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_b      (r_op[0]),
        .i_neg    (r_sign),
        .i_clear  (w_accept),
        .i_enable (w_shift),
        .o_bit    (w_bit)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)  w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_next = ST_DONE;
            ST_DONE:  if (w_release) w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_op          <= '0;
            r_res         <= '0;
            r_sign        <= 1'b0;
            r_minneg_pend <= 1'b0;
        end else if (w_accept) begin
            r_cnt         <= '0;
            r_op          <= in_data;
            r_res         <= '0;
            r_sign        <= in_data[WIDTH-1];
            r_minneg_pend <= in_data[WIDTH-1] && (in_data[WIDTH-2:0] == '0);
        end else if (w_shift) begin
            r_cnt <= r_cnt + 1'b1;
            r_op  <= r_op >> 1;
            r_res <= {w_bit, r_res[WIDTH-1:1]};
        end
    end

    // Result registers hold the last word after the handshake; only out_valid qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_sign   <= 1'b0;
            r_out_mag    <= '0;
            r_out_minneg <= 1'b0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_sign   <= r_sign;
            r_out_mag    <= r_res;
            r_out_minneg <= r_minneg_pend;
        end else if (w_release) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign out_sign   = r_out_sign;
    assign out_mag    = r_out_mag;
    assign out_minneg = r_out_minneg;
    assign dbg_state  = r_state;

endmodule
